// File: rtl/data_mem_ctrl.sv
// Data memory controller: 256 x 32-bit word memory behind a 4-entry in-order
// write buffer that holds committed stores. Loads and buffer drains share a
// single memory port. A load is accepted only when the buffer is not full and
// no buffered or incoming store targets the same word. Its response arrives
// one cycle later.
//
// Ports:
//   clk, reset            sole clock, synchronous active-high reset
//   store_wb/addr/data    committed store push (store_half: 0 = sw, 1 = sh)
//   store_ready           write buffer not full
//   load_req/addr/func3   load request (func3 3'b100 = lbu, else lw)
//   load_rob_tag/pd       tags echoed on the response
//   load_ready            load accepted this cycle when load_req is high
//   load_resp_*           one-cycle response pulse; fields are 0 when not valid
//   wb_count              write buffer occupancy 0..4
module data_mem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        store_wb,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
  input  logic        store_half,
  output logic        store_ready,
  input  logic        load_req,
  input  logic [31:0] load_addr,
  input  logic [2:0]  load_func3,
  input  logic [4:0]  load_rob_tag,
  input  logic [6:0]  load_pd,
  output logic        load_ready,
  output logic        load_resp_valid,
  output logic [31:0] load_resp_data,
  output logic [4:0]  load_resp_rob_tag,
  output logic [6:0]  load_resp_pd,
  output logic [2:0]  wb_count
);

  // Power-on contents are zero; reset never touches the array.
  logic [31:0] mem_q [256] = '{default: '0};

  logic [7:0]  wb_idx_q  [4];
  logic [31:0] wb_data_q [4];
  logic [3:0]  wb_be_q   [4];

  logic [1:0]  head_q, head_d, tail_q, tail_d;
  logic [2:0]  count_q, count_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [4:0]  resp_tag_q, resp_tag_d;
  logic [6:0]  resp_pd_q, resp_pd_d;

  logic        full, empty, push, hazard, load_acc, drain;
  logic [7:0]  ld_idx;
  logic [1:0]  slot;
  logic [31:0] push_data, rd_word;
  logic [3:0]  push_be;

  // Address bits outside the word index do not select storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{store_addr[31:10], store_addr[0], load_addr[31:10]};

  always_comb begin
    full   = (count_q == 3'd4);
    empty  = (count_q == 3'd0);
    push   = store_wb && !full;
    ld_idx = load_addr[9:2];

    // Block loads to any word with a pending or incoming store.
    hazard = push && (store_addr[9:2] == ld_idx);
    slot   = '0;
    for (int i = 0; i < 4; i++) begin
      slot = head_q + 2'(i);
      if ((3'(i) < count_q) && (wb_idx_q[slot] == ld_idx)) begin
        hazard = 1'b1;
      end
    end

    load_ready  = !full && !hazard;
    store_ready = !full;
    load_acc    = load_req && load_ready;
    // Occupancy is sampled before the push, so a fresh entry never drains at once.
    drain       = !empty && !load_acc;

    if (!store_half) begin
      push_be   = 4'b1111;
      push_data = store_data;
    end else if (store_addr[1]) begin
      push_be   = 4'b1100;
      push_data = {store_data[15:0], 16'h0000};
    end else begin
      push_be   = 4'b0011;
      push_data = {16'h0000, store_data[15:0]};
    end

    head_d  = drain ? head_q + 2'd1 : head_q;
    tail_d  = push ? tail_q + 2'd1 : tail_q;
    count_d = count_q;
    if (push && !drain) begin
      count_d = count_q + 3'd1;
    end else if (!push && drain) begin
      count_d = count_q - 3'd1;
    end

    rd_word      = mem_q[ld_idx];
    resp_valid_d = load_acc;
    resp_data_d  = '0;
    resp_tag_d   = '0;
    resp_pd_d    = '0;
    if (load_acc) begin
      resp_data_d = (load_func3 == 3'b100) ?
                    {24'h0, rd_word[{load_addr[1:0], 3'b000} +: 8]} : rd_word;
      resp_tag_d  = load_rob_tag;
      resp_pd_d   = load_pd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      resp_pd_q    <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      resp_pd_q    <= resp_pd_d;
    end
  end

  // Storage: gated by reset so a drain in the reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      wb_idx_q[tail_q]  <= store_addr[9:2];
      wb_data_q[tail_q] <= push_data;
      wb_be_q[tail_q]   <= push_be;
    end
    if (!reset && drain) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_be_q[head_q][b]) begin
          mem_q[wb_idx_q[head_q]][8*b +: 8] <= wb_data_q[head_q][8*b +: 8];
        end
      end
    end
  end

  assign load_resp_valid   = resp_valid_q;
  assign load_resp_data    = resp_data_q;
  assign load_resp_rob_tag = resp_tag_q;
  assign load_resp_pd      = resp_pd_q;
  assign wb_count          = count_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios followed by random traffic, all
// checked cycle by cycle against a queue-and-array model of the controller.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset, store_wb, store_half, load_req;
  logic [31:0] store_addr, store_data, load_addr;
  logic [2:0]  load_func3;
  logic [4:0]  load_rob_tag;
  logic [6:0]  load_pd;
  logic        store_ready, load_ready, load_resp_valid;
  logic [31:0] load_resp_data;
  logic [4:0]  load_resp_rob_tag;
  logic [6:0]  load_resp_pd;
  logic [2:0]  wb_count;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .store_wb          (store_wb),
    .store_addr        (store_addr),
    .store_data        (store_data),
    .store_half        (store_half),
    .store_ready       (store_ready),
    .load_req          (load_req),
    .load_addr         (load_addr),
    .load_func3        (load_func3),
    .load_rob_tag      (load_rob_tag),
    .load_pd           (load_pd),
    .load_ready        (load_ready),
    .load_resp_valid   (load_resp_valid),
    .load_resp_data    (load_resp_data),
    .load_resp_rob_tag (load_resp_rob_tag),
    .load_resp_pd      (load_resp_pd),
    .wb_count          (wb_count)
  );

  typedef struct {
    logic [7:0]  idx;
    logic [31:0] data;
    logic [3:0]  be;
  } wb_ent_t;

  // Reference model: memory image plus a list of stores not yet in memory.
  logic [31:0] mdl_mem [256];
  wb_ent_t     mdl_q [$];
  logic        exp_rv;
  logic [31:0] exp_rd;
  logic [4:0]  exp_rt;
  logic [6:0]  exp_rp;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cyc(input logic rst, input logic swb, input logic [31:0] saddr,
                     input logic [31:0] sdata, input logic shalf, input logic lreq,
                     input logic [31:0] laddr, input logic [2:0] f3,
                     input logic [4:0] tag, input logic [6:0] pd);
    logic    sready, lready, push, acc, haz;
    wb_ent_t e;
    logic [31:0] w;
    reset = rst; store_wb = swb; store_addr = saddr; store_data = sdata;
    store_half = shalf; load_req = lreq; load_addr = laddr; load_func3 = f3;
    load_rob_tag = tag; load_pd = pd;
    #5;
    sready = (mdl_q.size() < 4);
    push   = swb && sready;
    haz    = push && (saddr[9:2] == laddr[9:2]);
    foreach (mdl_q[k]) if (mdl_q[k].idx == laddr[9:2]) haz = 1'b1;
    lready = sready && !haz;
    check_eq("store_ready", 32'(store_ready), 32'(sready));
    check_eq("load_ready", 32'(load_ready), 32'(lready));
    check_eq("wb_count", 32'(wb_count), 32'(mdl_q.size()));
    check_eq("resp_valid", 32'(load_resp_valid), 32'(exp_rv));
    check_eq("resp_data", load_resp_data, exp_rd);
    check_eq("resp_tag", 32'(load_resp_rob_tag), 32'(exp_rt));
    check_eq("resp_pd", 32'(load_resp_pd), 32'(exp_rp));

    acc = lreq && lready;
    exp_rv = 1'b0; exp_rd = '0; exp_rt = '0; exp_rp = '0;
    if (rst) begin
      mdl_q.delete();
    end else begin
      if (acc) begin
        w      = mdl_mem[laddr[9:2]];
        exp_rv = 1'b1;
        exp_rd = (f3 == 3'b100) ? ((w >> (8 * laddr[1:0])) & 32'hFF) : w;
        exp_rt = tag;
        exp_rp = pd;
      end
      if (mdl_q.size() > 0 && !acc) begin
        e = mdl_q.pop_front();
        for (int b = 0; b < 4; b++)
          if (e.be[b]) mdl_mem[e.idx][8*b +: 8] = e.data[8*b +: 8];
      end
      if (push) begin
        e.idx = saddr[9:2];
        if (!shalf) begin
          e.be = 4'b1111; e.data = sdata;
        end else begin
          e.be   = saddr[1] ? 4'b1100 : 4'b0011;
          e.data = saddr[1] ? {sdata[15:0], 16'h0} : {16'h0, sdata[15:0]};
        end
        mdl_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b010, 5'h0, 7'h0);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0, 1'b0, 32'h0, 3'b010, 5'h0, 7'h0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] t,
                    input logic [6:0] p);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, a, f3, t, p);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
    exp_rv = 1'b0; exp_rd = '0; exp_rt = '0; exp_rp = '0;
    reset = 1'b1; store_wb = 1'b0; store_addr = '0; store_data = '0; store_half = 1'b0;
    load_req = 1'b0; load_addr = '0; load_func3 = '0; load_rob_tag = '0; load_pd = '0;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b010, 5'h0, 7'h0);

    // sw then lw of the same word with an idle cycle between.
    sw(32'h100, 32'hDEADBEEF);
    idle();
    ld(32'h100, 3'b010, 5'h15, 7'h2A);
    check_eq("s1_data", load_resp_data, 32'hDEADBEEF);
    check_eq("s1_tag", 32'(load_resp_rob_tag), 32'h15);
    check_eq("s1_pd", 32'(load_resp_pd), 32'h2A);

    // Halfword store into the upper half, then lbu and lw.
    sw(32'h100, 32'h11223344);
    idle();
    cyc(1'b0, 1'b1, 32'h102, 32'h0000ABCD, 1'b1, 1'b0, 32'h0, 3'b010, 5'h0, 7'h0);
    idle();
    ld(32'h103, 3'b100, 5'h1, 7'h1);
    check_eq("s2_lbu", load_resp_data, 32'h000000AB);
    ld(32'h100, 3'b010, 5'h2, 7'h2);
    check_eq("s2_lw", load_resp_data, 32'hABCD3344);

    // Five stores with loads held on another word: fills, drops the fifth.
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 32'h40 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b0,
          1'b1, 32'h380, 3'b010, 5'(i), 7'(i));
    check_eq("s3_full_cnt", 32'(wb_count), 32'd3);
    for (int i = 0; i < 4; i++) idle();
    for (int i = 0; i < 5; i++) begin
      ld(32'h40 + 32'(4 * i), 3'b010, 5'h3, 7'h3);
      check_eq("s3_word", load_resp_data, (i < 4) ? 32'hC0DE0000 + 32'(i) : 32'h0);
    end

    // Load to a word with a pending store waits for the drain.
    cyc(1'b0, 1'b1, 32'h200, 32'hA5B6C7D8, 1'b0, 1'b1, 32'h203, 3'b100, 5'h4, 7'h4);
    check_eq("s4_blocked", 32'(load_ready), 32'h0);
    ld(32'h203, 3'b100, 5'h4, 7'h4);
    ld(32'h203, 3'b100, 5'h4, 7'h4);
    check_eq("s4_byte", load_resp_data, 32'h000000A5);

    // Same-cycle store and load to one word.
    cyc(1'b0, 1'b1, 32'h300, 32'h5EED1234, 1'b0, 1'b1, 32'h300, 3'b010, 5'h5, 7'h5);
    check_eq("s5_blocked", 32'(load_ready), 32'h0);
    ld(32'h300, 3'b010, 5'h5, 7'h5);
    ld(32'h300, 3'b010, 5'h5, 7'h5);
    check_eq("s5_data", load_resp_data, 32'h5EED1234);

    // Reset with three stores pending, then alias read of word 0.
    sw(32'h000, 32'h0BADF00D);
    idle();
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 32'h10 + 32'(4 * i), 32'hFFFF0000 + 32'(i), 1'b0,
          1'b1, 32'h500, 3'b010, 5'h6, 7'h6);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h504, 3'b010, 5'h7, 7'h7);
    check_eq("s6_cnt", 32'(wb_count), 32'h0);
    check_eq("s6_no_resp", 32'(load_resp_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      ld(32'h10 + 32'(4 * i), 3'b010, 5'h8, 7'h8);
      check_eq("s6_unchanged", load_resp_data, 32'h0);
    end
    ld(32'h400, 3'b010, 5'h9, 7'h9);
    check_eq("s6_alias", load_resp_data, 32'h0BADF00D);

    // Random traffic over a few words with random aliasing bits.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] sa, la;
      sa = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      la = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, sa, $urandom,
          1'($urandom_range(0, 1)), $urandom_range(0, 1) == 1, la,
          ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b010, 5'($urandom), 7'($urandom));
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
